// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush squash and a saturating bubble counter
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Branch,
    input  logic             MemRead,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             ALUSrc,
    input  logic             RegWrite,
    input  logic [1:0]       ALUOp,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_Branch,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [1:0]       ex_ALUOp,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic [CNT_W-1:0] bubble_count
);
    logic hazard;
    logic ctrl_ok;

    // A load in EX whose destination feeds the instruction in ID; x0 never counts
    assign hazard  = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign stall   = hazard & ~flush & ~hold;
    // Controls load only for a real instruction with fully known control inputs
    assign ctrl_ok = id_valid & !$isunknown({Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp});

    // Pipeline register update: reset > flush > hold > bubble > load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid     <= 1'b0;
            ex_Branch    <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemtoReg  <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_ALUOp     <= 2'b00;
            ex_pc        <= '0;
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct     <= '0;
            if (reset)
                bubble_count <= '0;
        end else if (!hold) begin
            if (hazard) begin
                ex_valid    <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_ALUSrc   <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_ALUOp    <= 2'b00;
                if (bubble_count != {CNT_W{1'b1}})
                    bubble_count <= bubble_count + CNT_W'(1);
            end else begin
                ex_valid    <= id_valid;
                ex_Branch   <= ctrl_ok & Branch;
                ex_MemRead  <= ctrl_ok & MemRead;
                ex_MemtoReg <= ctrl_ok & MemtoReg & RegWrite;
                ex_MemWrite <= ctrl_ok & MemWrite;
                ex_ALUSrc   <= ctrl_ok & ALUSrc;
                ex_RegWrite <= ctrl_ok & RegWrite;
                ex_ALUOp    <= ctrl_ok ? ALUOp : 2'b00;
                ex_pc       <= id_pc;
                ex_rd1      <= id_rd1;
                ex_rd2      <= id_rd2;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct    <= id_funct;
            end
        end
    end
endmodule
